// File: rtl/bus_command_master.sv
// Single-outstanding MemoryBus master for host register commands.
// One response per accepted request: read data, write ack or timeout.
//
// Ports:
//   clock, reset        clock and synchronous active-high reset
//   req*                host request channel (reqValid/reqReady handshake)
//   rsp*                host response channel (rspValid held until rspReady)
//   busy                high whenever the master is not idle
//   ms*                 master-to-slave request side of the MemoryBus
//   sm*                 slave-to-master response side of the MemoryBus
// The MemoryBus master modport is flattened into plain ms*/sm* ports.
module bus_command_master #(
  parameter int DATA_WIDTH    = 24,
  parameter int ADDRESS_WIDTH = 32,
  parameter int ID_WIDTH      = 8,
  parameter int TIMEOUT       = 1024
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     reqValid,
  output logic                     reqReady,
  input  logic [ADDRESS_WIDTH-1:0] reqAddress,
  input  logic                     reqWrite,
  input  logic [DATA_WIDTH-1:0]    reqData,
  output logic                     rspValid,
  input  logic                     rspReady,
  output logic [DATA_WIDTH-1:0]    rspData,
  output logic                     rspTimeout,
  output logic                     busy,
  output logic                     msValid,
  input  logic                     msTaken,
  output logic [ADDRESS_WIDTH-1:0] msAddress,
  output logic                     msWrite,
  output logic [DATA_WIDTH-1:0]    msData,
  output logic [ID_WIDTH-1:0]      msID,
  input  logic                     smValid,
  output logic                     smTaken,
  input  logic [DATA_WIDTH-1:0]    smData,
  input  logic [ID_WIDTH-1:0]      smID
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] TLAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_RSP,
    RESPOND
  } state_e;

  state_e                   state_q;
  logic [ADDRESS_WIDTH-1:0] addr_q;
  logic                     write_q;
  logic [DATA_WIDTH-1:0]    wdata_q;
  logic [ID_WIDTH-1:0]      id_q;
  logic [ID_WIDTH-1:0]      idcnt_q;
  logic [CW-1:0]            tcnt_q;
  logic [DATA_WIDTH-1:0]    rdata_q;
  logic                     tout_q;

  logic expired;
  logic sm_hit;

  assign expired = (tcnt_q == TLAST);
  assign sm_hit  = (state_q == WAIT_RSP) &&
                   smValid && (smID == id_q);

  // Every slave response is taken: the matching one in
  // WAIT_RSP is captured, anything else is drained.
  assign smTaken = smValid;

  assign reqReady   = (state_q == IDLE);
  assign busy       = (state_q != IDLE);
  assign msValid    = (state_q == ISSUE);
  assign rspValid   = (state_q == RESPOND);
  assign msAddress  = addr_q;
  assign msWrite    = write_q;
  assign msData     = wdata_q;
  assign msID       = id_q;
  assign rspData    = rdata_q;
  assign rspTimeout = tout_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      write_q <= 1'b0;
      wdata_q <= '0;
      id_q    <= '0;
      idcnt_q <= '0;
      tcnt_q  <= '0;
      rdata_q <= '0;
      tout_q  <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (reqValid) begin
            addr_q  <= reqAddress;
            write_q <= reqWrite;
            wdata_q <= reqData;
            id_q    <= idcnt_q;
            tcnt_q  <= '0;
            state_q <= ISSUE;
          end
        end
        ISSUE: begin
          // A take on the expiry cycle still completes.
          if (msTaken) begin
            idcnt_q <= idcnt_q + ID_WIDTH'(1);
            tcnt_q  <= '0;
            if (write_q) begin
              rdata_q <= '0;
              tout_q  <= 1'b0;
              state_q <= RESPOND;
            end else begin
              state_q <= WAIT_RSP;
            end
          end else if (expired) begin
            // The abandoned ID is retired so a late
            // take cannot alias the next request.
            idcnt_q <= idcnt_q + ID_WIDTH'(1);
            rdata_q <= '0;
            tout_q  <= 1'b1;
            state_q <= RESPOND;
          end else begin
            tcnt_q <= tcnt_q + CW'(1);
          end
        end
        WAIT_RSP: begin
          if (sm_hit) begin
            rdata_q <= smData;
            tout_q  <= 1'b0;
            state_q <= RESPOND;
          end else if (expired) begin
            rdata_q <= '0;
            tout_q  <= 1'b1;
            state_q <= RESPOND;
          end else begin
            tcnt_q <= tcnt_q + CW'(1);
          end
        end
        RESPOND: begin
          if (rspReady) begin
            rdata_q <= '0;
            tout_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_command_master.sv
// Bench for bus_command_master: timeline model plus slave.
// Expected outputs are planned per cycle from request timing.
module tb_bus_command_master;

  localparam int TMO = 16;
  localparam int N   = 1024;

  logic        clock = 1'b0;
  logic        reset;
  logic        reqValid, reqReady, reqWrite;
  logic [31:0] reqAddress;
  logic [23:0] reqData;
  logic        rspValid, rspReady, rspTimeout, busy;
  logic [23:0] rspData;
  logic        msValid, msTaken, msWrite;
  logic [31:0] msAddress;
  logic [23:0] msData;
  logic [7:0]  msID;
  logic        smValid, smTaken;
  logic [23:0] smData;
  logic [7:0]  smID;

  bus_command_master #(
    .DATA_WIDTH(24), .ADDRESS_WIDTH(32),
    .ID_WIDTH(8), .TIMEOUT(TMO)
  ) dut (
    .clock(clock), .reset(reset),
    .reqValid(reqValid), .reqReady(reqReady),
    .reqAddress(reqAddress), .reqWrite(reqWrite),
    .reqData(reqData),
    .rspValid(rspValid), .rspReady(rspReady),
    .rspData(rspData), .rspTimeout(rspTimeout),
    .busy(busy),
    .msValid(msValid), .msTaken(msTaken),
    .msAddress(msAddress), .msWrite(msWrite),
    .msData(msData), .msID(msID),
    .smValid(smValid), .smTaken(smTaken),
    .smData(smData), .smID(smID)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int n_chk = 0;
  int n_fail = 0;
  bit chk_on = 0;

  // Planned outputs per cycle.
  bit          e_rr[N], e_busy[N], e_msv[N], e_wr[N];
  bit          e_rv[N], e_to[N];
  logic [7:0]  e_id[N];
  logic [31:0] e_addr[N];
  logic [23:0] e_wd[N], e_rd[N];

  logic [23:0] mem[logic [31:0]];
  logic [7:0]  id_m = 8'd0;

  int          last_rise;
  logic [23:0] last_data;
  logic        last_to;
  logic [7:0]  first_id;
  bit          rv_prev = 0, msv_prev = 0;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h",
               nm, cyc, act, exp);
    end
  endtask

  always @(negedge clock) begin
    if (chk_on) begin
      chk("reqReady", reqReady, e_rr[cyc]);
      chk("busy", busy, e_busy[cyc]);
      chk("msValid", msValid, e_msv[cyc]);
      chk("rspValid", rspValid, e_rv[cyc]);
      chk("smTaken", smTaken, smValid);
      if (e_msv[cyc]) begin
        chk("msID", msID, e_id[cyc]);
        chk("msAddress", msAddress, e_addr[cyc]);
        chk("msWrite", msWrite, e_wr[cyc]);
        if (e_wr[cyc]) chk("msData", msData, e_wd[cyc]);
      end
      if (e_rv[cyc]) begin
        chk("rspData", rspData, e_rd[cyc]);
        chk("rspTimeout", rspTimeout, e_to[cyc]);
      end
      if (rspValid && !rv_prev) begin
        last_rise = cyc;
        last_data = rspData;
        last_to   = rspTimeout;
      end
      if (msValid && !msv_prev) first_id = msID;
      rv_prev  = rspValid;
      msv_prev = msValid;
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [23:0] rd_mem(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return 24'h0;
  endfunction

  // take: cycles msValid waits for msTaken (>=TMO: never)
  // rlat: cycles after take until the slave answers
  // hold: extra cycles rspReady is kept low
  // foff: ID offset of a foreign response (0: none)
  task automatic txn(input bit wr, input logic [31:0] a,
                     input logic [23:0] d, input int take,
                     input int rlat, input int hold,
                     input int foff, output int h);
    int t, rs, ie;
    bit to;
    logic [23:0] ed;
    logic [7:0] id;
    h  = cyc;
    id = id_m;
    t  = h + 1 + take;
    ed = 24'h0;
    to = 1'b0;
    if (take >= TMO) begin
      ie = h + TMO;
      rs = h + 1 + TMO;
      to = 1'b1;
    end else begin
      ie = t;
      if (wr) rs = t + 1;
      else if (rlat >= TMO) begin
        rs = t + 1 + TMO;
        to = 1'b1;
      end else begin
        rs = t + 2 + rlat;
        ed = rd_mem(a);
      end
    end
    for (int c = h + 1; c <= rs + hold; c++) begin
      e_rr[c] = 0;
      e_busy[c] = 1;
    end
    for (int c = h + 1; c <= ie; c++) begin
      e_msv[c] = 1;
      e_id[c] = id;
      e_addr[c] = a;
      e_wr[c] = wr;
      e_wd[c] = d;
    end
    for (int c = rs; c <= rs + hold; c++) begin
      e_rv[c] = 1;
      e_rd[c] = ed;
      e_to[c] = to;
    end
    reqValid = 1;
    reqAddress = a;
    reqWrite = wr;
    reqData = d;
    step();
    while (cyc <= rs + hold) begin
      reqAddress = $urandom;
      reqData = 24'($urandom);
      reqWrite = 1'($urandom);
      // offers during RESPOND must be ignored
      reqValid = (cyc >= rs);
      msTaken = (take < TMO) && (cyc == t);
      smValid = 0;
      smID = 8'($urandom);
      smData = 24'($urandom);
      if (foff != 0 && !wr && take < TMO
          && cyc == t + 1) begin
        smValid = 1;
        smID = id + 8'(foff);
        smData = 24'hBADBAD;
      end
      if (!wr && take < TMO && rlat < TMO
          && cyc == t + 1 + rlat) begin
        smValid = 1;
        smID = id;
        smData = ed;
      end
      rspReady = (cyc == rs + hold);
      step();
    end
    reqValid = 0;
    rspReady = 0;
    msTaken = 0;
    smValid = 0;
    if (wr && take < TMO) mem[a] = d;
    id_m = id_m + 8'd1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired cyc=%0d", cyc);
    $fatal(1);
  end

  initial begin
    int h, c;
    logic [7:0] stale;
    for (int i = 0; i < N; i++) begin
      e_rr[i] = 1; e_busy[i] = 0; e_msv[i] = 0;
      e_wr[i] = 0; e_rv[i] = 0; e_to[i] = 0;
      e_id[i] = 0; e_addr[i] = 0;
      e_wd[i] = 0; e_rd[i] = 0;
    end
    reset = 1; reqValid = 0; reqAddress = 0;
    reqWrite = 0; reqData = 0; rspReady = 0;
    msTaken = 0; smValid = 0; smData = 0; smID = 0;
    step();
    step();
    reset = 0;
    chk_on = 1;
    chk("rst_reqReady", reqReady, 1);
    chk("rst_busy", busy, 0);
    chk("rst_msID", msID, 0);
    chk("rst_rspValid", rspValid, 0);
    step();

    txn(1, 32'h11, 24'h0001E0, 0, 0, 0, 0, h);
    chk("wr_latency", last_rise - h, 2);
    chk("wr_rspData", last_data, 0);
    txn(1, 32'h10, 24'h000280, 0, 0, 0, 0, h);
    txn(0, 32'h10, 24'h0, 0, 0, 1, 0, h);
    chk("rd_latency", last_rise - h, 3);
    chk("rd_rspData", last_data, 24'h000280);
    txn(0, 32'hFFFF0000, 24'h0, TMO, 0, 0, 0, h);
    chk("tmo_latency", last_rise - h, 17);
    chk("tmo_flag", last_to, 1);
    txn(0, 32'h10, 24'h0, 2, 3, 10, 0, h);
    chk("id_after_tmo", first_id, 8'd4);
    txn(0, 32'h11, 24'h0, 1, 4, 0, 5, h);
    chk("drain_data", last_data, 24'h0001E0);
    txn(0, 32'h10, 24'h0, 1, TMO, 0, 0, h);
    chk("wait_tmo_lat", last_rise - h, 19);
    txn(1, 32'h20, 24'h123456, TMO - 1, 0, 0, 0, h);
    chk("take_at_expiry", last_to, 0);
    chk("expiry_wr_lat", last_rise - h, 17);
    txn(0, 32'h20, 24'h0, 0, TMO - 1, 0, 0, h);
    chk("rsp_at_expiry", last_data, 24'h123456);

    // reset while waiting for read data
    c = cyc;
    stale = id_m;
    for (int k = c + 1; k <= c + 3; k++) begin
      e_rr[k] = 0;
      e_busy[k] = 1;
    end
    e_msv[c + 1] = 1;
    e_id[c + 1] = stale;
    e_addr[c + 1] = 32'h10;
    e_wr[c + 1] = 0;
    reqValid = 1; reqAddress = 32'h10; reqWrite = 0;
    step();
    reqValid = 0;
    msTaken = 1;
    step();
    msTaken = 0;
    step();
    reset = 1;
    step();
    reset = 0;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_msID", msID, 0);
    chk("mid_rst_rspValid", rspValid, 0);
    step();
    smValid = 1; smID = stale; smData = 24'hDEAD00;
    step();
    smValid = 0;
    id_m = 8'd0;
    txn(0, 32'h11, 24'h0, 0, 3, 0, int'(stale), h);
    chk("post_rst_id", first_id, 8'd0);
    chk("post_rst_data", last_data, 24'h0001E0);
    step();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
